// File: rtl/insn_mem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding and the number of stream bytes packed into one instruction word.
package insn_mem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   localparam int INSN_WORD_BYTES = 4;

endpackage

// File: rtl/insn_mem_loader_byte_packer.sv
// Little-endian byte packer: assembles four accepted bytes into a 32-bit word,
// first byte in bits 7:0. o_word already includes the byte accepted this cycle.
module insn_mem_loader_byte_packer
   import insn_mem_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_accept,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_full
);

   logic [1:0]  r_cnt;
   logic [31:0] r_word;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_word <= '0;
      end else if (i_clr) begin
         r_cnt  <= '0;
      end else if (i_accept) begin
         r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
         r_cnt                        <= r_cnt + 2'd1;
      end
   end

   // Bypass the incoming byte so the complete word is visible on the final accept.
   always_comb begin
      o_word = r_word;
      if (i_accept)
         o_word[{r_cnt, 3'b000} +: 8] = i_byte;
   end

   assign o_word_full = i_accept && (r_cnt == 2'(INSN_WORD_BYTES - 1));

endmodule

// File: rtl/insn_mem_loader.sv
// Boot-time instruction-memory writer: reads a 16-bit word count and program
// words from a byte stream and issues one aligned write per word, holding the CPU meanwhile.
module insn_mem_loader
   import insn_mem_loader_pkg::*;
#(
   parameter int          DEPTH     = 201,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready,
   output logic        o_wr_en,
   output logic [31:0] o_wr_addr,
   output logic [31:0] o_wr_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic        o_cpu_hold
);

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t      r_state;
   logic [15:0] r_count;
   logic [15:0] r_word_idx;

   logic        w_accept;
   logic        w_data_acc;
   logic        w_start_ok;
   logic [15:0] w_len;
   logic [15:0] w_idx_next;
   logic [31:0] w_word;
   logic        w_word_full;

   assign w_accept   = i_rx_valid && o_rx_ready;
   assign w_data_acc = w_accept && (r_state == ST_DATA);
   assign w_start_ok = i_start &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
   assign w_len      = {i_rx_data, r_count[7:0]};
   assign w_idx_next = r_word_idx + 16'd1;

   insn_mem_loader_byte_packer u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_reset),
      .i_clr       (w_start_ok),
      .i_accept    (w_data_acc),
      .i_byte      (i_rx_data),
      .o_word      (w_word),
      .o_word_full (w_word_full)
   );

   // All outputs are registered alongside the state they belong to.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_count    <= '0;
         r_word_idx <= '0;
         o_rx_ready <= 1'b0;
         o_wr_en    <= 1'b0;
         o_wr_addr  <= BASE_ADDR;
         o_wr_data  <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         o_cpu_hold <= 1'b0;
      end else begin
         o_wr_en <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (i_start) begin
                  r_state    <= ST_LEN0;
                  r_word_idx <= '0;
                  o_done     <= 1'b0;
                  o_err      <= 1'b0;
                  o_rx_ready <= 1'b1;
                  o_busy     <= 1'b1;
                  o_cpu_hold <= 1'b1;
               end
            end
            ST_LEN0: begin
               if (w_accept) begin
                  r_count[7:0] <= i_rx_data;
                  r_state      <= ST_LEN1;
               end
            end
            ST_LEN1: begin
               if (w_accept) begin
                  r_count <= w_len;
                  if (w_len == 16'd0) begin
                     r_state    <= ST_DONE;
                     o_done     <= 1'b1;
                     o_rx_ready <= 1'b0;
                     o_busy     <= 1'b0;
                     o_cpu_hold <= 1'b0;
                  end else if ({1'b0, w_len} > DEPTH_L) begin
                     r_state    <= ST_ERR;
                     o_err      <= 1'b1;
                     o_rx_ready <= 1'b0;
                     o_busy     <= 1'b0;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_word_full) begin
                  r_state    <= ST_WRITE;
                  o_rx_ready <= 1'b0;
                  o_wr_en    <= 1'b1;
                  o_wr_data  <= w_word;
                  o_wr_addr  <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
               end
            end
            ST_WRITE: begin
               r_word_idx <= w_idx_next;
               if (w_idx_next == r_count) begin
                  r_state    <= ST_DONE;
                  o_done     <= 1'b1;
                  o_busy     <= 1'b0;
                  o_cpu_hold <= 1'b0;
               end else begin
                  r_state    <= ST_DATA;
                  o_rx_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               o_rx_ready <= 1'b0;
               o_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_insn_mem_loader.sv
// Directed bench for insn_mem_loader: expected writes are queued as bytes are
// streamed in and checked against every wr_en pulse.
module tb_insn_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_hold;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          n_wr     = 0;
   logic [31:0] last_addr = '0;

   insn_mem_loader #(.DEPTH(201), .BASE_ADDR(32'h0000_0000)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_start    (start),
      .i_rx_data  (rx_data),
      .i_rx_valid (rx_valid),
      .o_rx_ready (rx_ready),
      .o_wr_en    (wr_en),
      .o_wr_addr  (wr_addr),
      .o_wr_data  (wr_data),
      .o_busy     (busy),
      .o_done     (done),
      .o_err      (err),
      .o_cpu_hold (cpu_hold)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write strobe pops the oldest expected write.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && wr_en) begin
         n_wr++;
         last_addr = wr_addr;
         e.addr = 32'hFFFF_FFFF;
         e.data = 32'hFFFF_FFFF;
         if (exp_q.size() != 0)
            e = exp_q.pop_front();
         chk("wr_addr", wr_addr, e.addr);
         chk("wr_data", wr_data, e.data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got = 1'b0;
      for (int g = 0; g < gap; g++) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         tick();
      end
      rx_data  = b;
      rx_valid = 1'b1;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         if (rx_ready) begin
            tick();
            got = 1'b1;
         end
      end
      if (!got)
         chk("accept_timeout", {31'b0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
   endtask

   task automatic send_count(input logic [15:0] c);
      send_byte(c[7:0], 0);
      send_byte(c[15:8], 0);
   endtask

   task automatic send_word(input logic [31:0] a, input logic [31:0] d, input int maxgap);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++)
         send_byte(d[8*k +: 8], int'($urandom_range(maxgap, 0)));
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
      chk({pfx, "_wr_en"},    {31'b0, wr_en},    32'd0);
      chk({pfx, "_wr_addr"},  wr_addr,           32'h0);
      chk({pfx, "_wr_data"},  wr_data,           32'h0);
      chk({pfx, "_busy"},     {31'b0, busy},     32'd0);
      chk({pfx, "_done"},     {31'b0, done},     32'd0);
      chk({pfx, "_err"},      {31'b0, err},      32'd0);
      chk({pfx, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
   endtask

   initial begin
      int w0;
      rst      = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) tick();
      chk_reset_outputs("rst");
      rst = 1'b0;
      tick();

      // two-word load, rx_valid held high
      pulse_start();
      chk("t1_rx_ready", {31'b0, rx_ready}, 32'd1);
      chk("t1_busy",     {31'b0, busy},     32'd1);
      chk("t1_cpu_hold", {31'b0, cpu_hold}, 32'd1);
      w0 = n_wr;
      send_count(16'd2);
      send_word(32'h0, 32'h1234_5678, 0);
      send_word(32'h4, 32'hDEAD_BEEF, 0);
      chk("t1_wr_en_after_last_byte", {31'b0, wr_en}, 32'd1);
      tick();
      chk("t1_done",     {31'b0, done},     32'd1);
      chk("t1_cpu_hold", {31'b0, cpu_hold}, 32'd0);
      chk("t1_busy",     {31'b0, busy},     32'd0);
      chk("t1_rx_ready", {31'b0, rx_ready}, 32'd0);
      chk("t1_wr_count", 32'(n_wr - w0),    32'd2);

      // zero count
      pulse_start();
      chk("t2_done_cleared", {31'b0, done}, 32'd0);
      w0 = n_wr;
      send_count(16'd0);
      chk("t2_done", {31'b0, done}, 32'd1);
      chk("t2_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("t2_wr_count", 32'(n_wr - w0), 32'd0);

      // full-depth load, then one word too many
      pulse_start();
      w0 = n_wr;
      send_count(16'd201);
      for (int i = 0; i < 201; i++)
         send_word(32'(4 * i), 32'(i) * 32'h9E37_79B9 + 32'h0000_1234, 0);
      tick();
      chk("t3_done",      {31'b0, done},     32'd1);
      chk("t3_last_addr", last_addr,         32'h320);
      chk("t3_wr_count",  32'(n_wr - w0),    32'd201);
      pulse_start();
      w0 = n_wr;
      send_count(16'd202);
      chk("t3_err",      {31'b0, err},      32'd1);
      chk("t3_cpu_hold", {31'b0, cpu_hold}, 32'd1);
      chk("t3_rx_ready", {31'b0, rx_ready}, 32'd0);
      chk("t3_busy",     {31'b0, busy},     32'd0);
      chk("t3_done",     {31'b0, done},     32'd0);
      rx_valid = 1'b1;
      repeat (5) tick();
      rx_valid = 1'b0;
      chk("t3_err_wr_count", 32'(n_wr - w0), 32'd0);
      chk("t3_err_sticky",   {31'b0, err},   32'd1);

      // stalled stream with garbage on idle cycles
      pulse_start();
      chk("t4_err_cleared", {31'b0, err}, 32'd0);
      w0 = n_wr;
      send_count(16'd2);
      send_word(32'h0, 32'h1234_5678, 5);
      send_word(32'h4, 32'hDEAD_BEEF, 5);
      tick();
      chk("t4_done",     {31'b0, done},  32'd1);
      chk("t4_wr_count", 32'(n_wr - w0), 32'd2);

      // reset after six data bytes, then a fresh one-word load
      pulse_start();
      w0 = n_wr;
      send_count(16'd3);
      send_word(32'h0, 32'hCAFE_F00D, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("t5");
      tick();
      rst = 1'b0;
      tick();
      pulse_start();
      send_count(16'd1);
      send_word(32'h0, 32'h0BAD_C0DE, 0);
      tick();
      chk("t5_done",     {31'b0, done},  32'd1);
      chk("t5_wr_count", 32'(n_wr - w0), 32'd2);

      // start pulse in DATA must not restart
      pulse_start();
      w0 = n_wr;
      send_count(16'd2);
      begin
         wr_t e;
         e.addr = 32'h0;
         e.data = 32'h1122_3344;
         exp_q.push_back(e);
      end
      send_byte(8'h44, 0);
      send_byte(8'h33, 0);
      pulse_start();
      chk("t6_busy_after_start", {31'b0, busy}, 32'd1);
      send_byte(8'h22, 0);
      send_byte(8'h11, 0);
      send_word(32'h4, 32'h5566_7788, 0);
      tick();
      chk("t6_done",     {31'b0, done},  32'd1);
      chk("t6_wr_count", 32'(n_wr - w0), 32'd2);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
